// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and op classification for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SGT   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_SRA   = 4'd14;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider over a 2*DATA_WIDTH accumulator.
// One step per cycle; last_o flags the final step, with res_o valid in that same cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q;
  logic [CntW-1:0] cnt_q;
  logic            active_q, is_mul_q, want_hi_q;
  logic [W:0]      sum, rem_sh, diff;
  logic            start_mul;

  assign start_mul = (op_i == OP_MUL) || (op_i == OP_MULHU);
  assign last_o    = active_q && (cnt_q == CntW'(W - 1));

  // Mul: hi += multiplicand when lsb set, then shift right.
  // Div: shift left, subtract divisor from hi if it fits; a zero divisor naturally
  // yields quotient all ones and remainder equal to the dividend.
  always_comb begin
    sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    rem_sh = acc_q[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opnd_q};
    if (is_mul_q) begin
      acc_d = acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    end else if (!diff[W]) begin
      acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  assign res_o = want_hi_q ? acc_d[2*W-1:W] : acc_d[W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_mul_q  <= 1'b0;
      want_hi_q <= 1'b0;
    end else if (start_i) begin
      active_q  <= 1'b1;
      cnt_q     <= '0;
      is_mul_q  <= start_mul;
      want_hi_q <= (op_i == OP_MULHU) || (op_i == OP_REMU);
      opnd_q    <= start_mul ? a_i : b_i;
      acc_q     <= {{W{1'b0}}, (start_mul ? b_i : a_i)};
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (last_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative mul/div behind
// valid/ready handshakes, with a registered result.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [SEL_WIDTH-1:0]  opSel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  div_by_zero,
  output logic                  busy
);

  alu_state_e            state_q;
  logic [DATA_WIDTH-1:0] result_q, alu_res, md_res;
  logic                  zero_q, dbz_q, md_last, accept;
  logic [3:0]            op;
  logic [SHAMT_W-1:0]    shamt;

  assign op       = opSel[3:0];
  assign shamt    = operand2[SHAMT_W-1:0];
  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign accept   = in_valid && in_ready;

  assign out_valid   = (state_q == StDone);
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = operand1 + operand2;
      OP_SUB:  alu_res = operand1 - operand2;
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, operand1 < operand2};
      OP_SGT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, operand1 > operand2};
      OP_SLL:  alu_res = operand1 << shamt;
      OP_SRL:  alu_res = operand1 >> shamt;
      OP_SRA:  alu_res = DATA_WIDTH'($signed(operand1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(accept && is_iterative(op)),
    .op_i   (op),
    .a_i    (operand1),
    .b_i    (operand2),
    .last_o (md_last),
    .res_o  (md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            dbz_q <= ((op == OP_DIVU) || (op == OP_REMU)) && (operand2 == '0);
            if (is_iterative(op)) begin
              state_q <= StIter;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              state_q  <= StDone;
            end
          end
        end
        StIter: begin
          if (md_last) begin
            result_q <= md_res;
            zero_q   <= (md_res == '0);
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed cases plus randomized ops against an
// arithmetic reference model; a monitor checks every presented result.
module tb_alu_mc;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 0, rst = 1;
  logic         in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [W-1:0] operand1 = '0, operand2 = '0, result;
  logic [3:0]   opSel = '0;
  logic         zero, div_by_zero, busy;

  int   checks = 0, errors = 0, cyc = 0;
  bit   rand_ready = 0, seen = 0;
  exp_t sb[$];

  alu_mc dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand1   (operand1),
    .operand2   (operand2),
    .opSel      (opSel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned p;
    int sh;
    p  = longint'(a) * longint'(b);
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return ~(a | b);
      5:  return a ^ b;
      6:  return (a < b) ? 1 : 0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return (a > b) ? 1 : 0;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      14: return W'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  // Holds the request until accepted; push=0 issues without expecting a result.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push = 1);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_valid = 1; opSel = op; operand1 = a; operand2 = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 32'(in_ready), 1);
      in_valid = 0;
      return;
    end
    e.res = model(op, a, b);
    e.z   = (e.res == 0);
    e.dbz = (op == 12 || op == 13) && (b == 0);
    e.acc = cyc;
    e.lat = (op >= 10 && op <= 13) ? W + 1 : 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0; opSel = 4'($urandom); operand1 = $urandom; operand2 = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 0);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
        check("result", result, sb[0].res);
        check("zero", 32'(zero), 32'(sb[0].z));
        check("div_by_zero", 32'(div_by_zero), 32'(sb[0].dbz));
        check("in_ready_while_valid", 32'(in_ready), 0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] op;
    logic [W-1:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_dbz", 32'(div_by_zero), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 0;

    out_ready = 1;
    issue(0, 32'hFFFF_FFFF, 32'h1);            drain();
    issue(14, 32'h8000_0000, 32'h0000_0104);   drain();
    issue(8, 32'h8000_0000, 32'h0000_0104);    drain();
    issue(10, 32'hFFFF_FFFF, 32'h2);           drain();
    issue(11, 32'hFFFF_FFFF, 32'h2);           drain();
    issue(12, 100, 7);                         drain();
    issue(13, 100, 7);                         drain();
    issue(12, 5, 0);                           drain();
    issue(13, 5, 0);                           drain();
    issue(15, 32'h1234, 32'h5678);             drain();

    // Backpressure: hold result for 5 extra cycles.
    out_ready = 0;
    issue(1, 10, 3);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("bp_busy", 32'(busy), 1);
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 1);
    check("bp_out_valid_after", 32'(out_valid), 0);

    // Reset mid-divide discards the result.
    issue(12, 1000, 3, 0);
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_in_ready", 32'(in_ready), 1);
    check("rst_mid_out_valid", 32'(out_valid), 0);
    repeat (40) @(negedge clk);
    check("rst_mid_no_valid", 32'(out_valid), 0);
    issue(0, 2, 3);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      issue(op, a, b);
    end
    drain();
    rand_ready = 0;
    out_ready  = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor to the combinational single-cycle ALU.
- Keeps the 4-bit opSel encoding for ops 0-9.
- Adds iterative multiply and unsigned divide/remainder, arithmetic shift right, a registered result, and valid/ready handshakes on input and output.
- Sits in the execute stage of the pipelined core: the stall unit holds issue while in_ready is low.

Parameters:
- DATA_WIDTH, 32, operand/result width (>=8, power of 2).
- SEL_WIDTH, 4, opSel width.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- operand1  in  DATA_WIDTH  first operand (dividend, multiplicand, shift source).
- operand2  in  DATA_WIDTH  second operand; shift amount = operand2[SHAMT_W-1:0].
- opSel  in  SEL_WIDTH  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  DATA_WIDTH  registered result.
- zero  out  1  result == 0, registered with result.
- div_by_zero  out  1  DIVU/REMU issued with operand2 == 0; valid with out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is synchronous, active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=1, div_by_zero=0, counter=0.
- Opcodes, all compares unsigned:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLT, 9 SGT: result 1 or 0.
  - 7 SLL, 8 SRL, 14 SRA: shift by operand2[SHAMT_W-1:0].
  - 10 MUL: low DATA_WIDTH bits of the product.
  - 11 MULHU: high DATA_WIDTH bits of the unsigned product.
  - 12 DIVU, 13 REMU.
  - 15 (undefined): result 0 with 1-cycle latency.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no carry/overflow output.
- FSM states: IDLE, ITER, DONE.
  - in_ready = (state==IDLE). A handshake occurs when in_valid & in_ready.
  - IDLE -> DONE on a handshake with a single-cycle op; result latched that edge. Accept in cycle N -> out_valid in cycle N+1.
  - IDLE -> ITER on a handshake with op 10-13; operands and op latched, counter=0.
  - ITER: one shift-add (MUL/MULHU) or restoring-subtract (DIVU/REMU) step per cycle, over a 2*DATA_WIDTH accumulator.
  - ITER -> DONE when counter==DATA_WIDTH-1. Accept in cycle N -> out_valid in cycle N+DATA_WIDTH+1.
  - DONE: out_valid=1; result, zero and div_by_zero held stable.
  - DONE -> IDLE on out_ready. No new accept in that same cycle, so throughput is at most one op every 2 cycles.
- Divide by zero: detected at accept, but the op still takes the full iterative latency (fixed latency).
  - DIVU result = all ones; REMU result = operand1; div_by_zero=1.
  - div_by_zero=0 for all other ops.
- Operand inputs are ignored outside the accept cycle; changes during ITER have no effect.
- in_valid while busy: not accepted; the requester holds the request.
- rst asserted mid-ITER or in DONE: returns to IDLE next edge; the pending result is discarded and out_valid drops.
- zero is computed from the final registered result, never from intermediate iteration values.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_SRA, values 0-14);
  - state enum encoding IDLE=0, ITER=1, DONE=2;
  - is_iterative(op) function.
- Sub-module alu_muldiv_iter holds the accumulator, counter and step datapath, with a start/done interface and DATA_WIDTH parameter.
- The top block holds the FSM, handshakes and the single-cycle ops.

Test Plan (DATA_WIDTH=32):
- ADD 0xFFFFFFFF + 0x1, out_ready=1 -> out_valid one cycle after accept, result 0x0, zero=1.
- SRA 0x80000000 by operand2=0x00000104 (shamt 4) -> result 0xF8000000. SRL with same operands -> 0x08000000.
- MUL 0xFFFFFFFF * 0x2 -> result 0xFFFFFFFE at accept+33. MULHU with same operands -> 0x00000001.
- DIVU 100 / 7 -> result 14. REMU 100 / 7 -> result 2. DIVU 5 / 0 -> result 0xFFFFFFFF, div_by_zero=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0. out_ready=1 -> IDLE next cycle.
- rst pulse at cycle 10 of a DIVU -> out_valid never asserts, in_ready=1 the cycle after reset deasserts. A following ADD 2+3 returns 5.
